// File: rtl/llc_oram_bridge_pkg.sv
// Shared constants for the LLC-to-ORAM bridge: front-end command encodings
// and elaboration-time helpers.
package llc_oram_bridge_pkg;

    localparam logic [1:0] FECMD_Update  = 2'd0;
    localparam logic [1:0] FECMD_Append  = 2'd1;
    localparam logic [1:0] FECMD_Read    = 2'd2;
    localparam logic [1:0] FECMD_ReadRmv = 2'd3;

    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        while ((32'sd1 << result) < value) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

    // Update and Append carry a line to the front end; the others return one.
    function automatic logic isWriteCmd(input logic [1:0] cmd);
        return (cmd == FECMD_Update) || (cmd == FECMD_Append);
    endfunction

endpackage

// File: rtl/llc_oram_bridge_line_chunk_shifter.sv
// Line-wide register with parallel load and chunk-wide right shift; the low
// chunk is the serial output, the serial input enters at the MSBs.
module line_chunk_shifter #(
    parameter int ORAMB    = 512,
    parameter int FEDWidth = 32
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Load,
    input  logic [ORAMB-1:0]    LoadData,
    input  logic                Shift,
    input  logic [FEDWidth-1:0] ShiftIn,
    output logic [ORAMB-1:0]    Line,
    output logic [FEDWidth-1:0] LowChunk
);

    // Line register: load wins over shift; the concatenate-and-shift form
    // also covers the single-chunk case where nothing of the old line survives.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Line <= '0;
        end else if (Load) begin
            Line <= LoadData;
        end else if (Shift) begin
            Line <= ORAMB'({ShiftIn, Line} >> FEDWidth);
        end else begin
            Line <= Line;
        end
    end

    assign LowChunk = Line[FEDWidth-1:0];

endmodule

// File: rtl/llc_oram_bridge.sv
// Bridge between the LLC miss path and the ORAM front end: one command per
// request, write lines serialized into chunks, read chunks reassembled.
module llc_oram_bridge
    import llc_oram_bridge_pkg::*;
#(
    parameter int ORAMU    = 32,
    parameter int ORAMB    = 512,
    parameter int FEDWidth = 32
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                ReqValid,
    output logic                ReqReady,
    input  logic [1:0]          ReqCmd,
    input  logic [ORAMU-1:0]    ReqAddr,
    input  logic [ORAMB-1:0]    ReqData,
    output logic                RespValid,
    input  logic                RespReady,
    output logic [ORAMB-1:0]    RespData,
    output logic                CmdInValid,
    input  logic                CmdInReady,
    output logic [1:0]          CmdIn,
    output logic [ORAMU-1:0]    ProgAddrIn,
    output logic                DataInValid,
    input  logic                DataInReady,
    output logic [FEDWidth-1:0] DataIn,
    input  logic                ReturnDataValid,
    output logic                ReturnDataReady,
    input  logic [FEDWidth-1:0] ReturnData
);

    localparam int Chunks     = ORAMB / FEDWidth;
    localparam int CountWidth = (clog2(Chunks) < 32'sd1) ? 32'sd1 : clog2(Chunks);
    localparam logic [CountWidth-1:0] LastCount = CountWidth'(Chunks - 32'sd1);

    if (ORAMB % FEDWidth != 32'sd0) begin : gParamCheck
        $error("llc_oram_bridge: ORAMB must be a multiple of FEDWidth");
    end

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StCmd    = 3'd1,
        StWrData = 3'd2,
        StRdData = 3'd3,
        StResp   = 3'd4
    } state_t;

    state_t                  state_r;
    state_t                  nextState_s;
    logic [CountWidth-1:0]   count_r;
    logic                    reqFire_s;
    logic                    cmdFire_s;
    logic                    wrFire_s;
    logic                    rdFire_s;
    logic                    respFire_s;
    logic                    lastChunk_s;
    logic [FEDWidth-1:0]     shiftIn_s;
    logic [ORAMB-1:0]        line_s;
    logic [FEDWidth-1:0]     lowChunk_s;

    // Handshakes are taken from the registered valid/ready outputs.
    assign reqFire_s   = ReqValid & ReqReady;
    assign cmdFire_s   = CmdInValid & CmdInReady;
    assign wrFire_s    = DataInValid & DataInReady;
    assign rdFire_s    = ReturnDataValid & ReturnDataReady;
    assign respFire_s  = RespValid & RespReady;
    assign lastChunk_s = (count_r == LastCount);
    assign shiftIn_s   = rdFire_s ? ReturnData : '0;

    line_chunk_shifter #(
        .ORAMB    (ORAMB),
        .FEDWidth (FEDWidth)
    ) uShifter (
        .Clock    (Clock),
        .Reset    (Reset),
        .Load     (reqFire_s),
        .LoadData (ReqData),
        .Shift    (wrFire_s | rdFire_s),
        .ShiftIn  (shiftIn_s),
        .Line     (line_s),
        .LowChunk (lowChunk_s)
    );

    assign DataIn   = lowChunk_s;
    assign RespData = line_s;

    // Next-state decode.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            StIdle: begin
                if (reqFire_s) nextState_s = StCmd;
                else           nextState_s = StIdle;
            end
            StCmd: begin
                if (cmdFire_s) nextState_s = isWriteCmd(CmdIn) ? StWrData : StRdData;
                else           nextState_s = StCmd;
            end
            StWrData: begin
                if (wrFire_s && lastChunk_s) nextState_s = StIdle;
                else                         nextState_s = StWrData;
            end
            StRdData: begin
                if (rdFire_s && lastChunk_s) nextState_s = StResp;
                else                         nextState_s = StRdData;
            end
            StResp: begin
                if (respFire_s) nextState_s = StIdle;
                else            nextState_s = StResp;
            end
            default: nextState_s = StIdle;
        endcase
    end

    // State and handshake outputs, registered from the next state so each
    // valid/ready is a flop and all of them read 0 after a reset edge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r         <= StIdle;
            ReqReady        <= 1'b0;
            CmdInValid      <= 1'b0;
            DataInValid     <= 1'b0;
            ReturnDataReady <= 1'b0;
            RespValid       <= 1'b0;
        end else begin
            state_r         <= nextState_s;
            ReqReady        <= (nextState_s == StIdle);
            CmdInValid      <= (nextState_s == StCmd);
            DataInValid     <= (nextState_s == StWrData);
            ReturnDataReady <= (nextState_s == StRdData);
            RespValid       <= (nextState_s == StResp);
        end
    end

    // Command payload captured on request acceptance.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            CmdIn      <= 2'd0;
            ProgAddrIn <= '0;
        end else if (reqFire_s) begin
            CmdIn      <= ReqCmd;
            ProgAddrIn <= ReqAddr;
        end else begin
            CmdIn      <= CmdIn;
            ProgAddrIn <= ProgAddrIn;
        end
    end

    // Chunk counter; wraps to zero on the last chunk of either direction.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_r <= '0;
        end else if (wrFire_s || rdFire_s) begin
            count_r <= lastChunk_s ? '0 : count_r + CountWidth'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: tb/tb_llc_oram_bridge.sv
// Self-checking bench for llc_oram_bridge: directed scenarios plus randomized
// transactions checked against a chunk-level reference model.
module tb_llc_oram_bridge;

    localparam int U = 32;
    localparam int B = 512;
    localparam int F = 32;
    localparam int N = B / F;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         ReqValid, ReqReady, RespValid, RespReady;
    logic [1:0]   ReqCmd, CmdIn;
    logic [U-1:0] ReqAddr, ProgAddrIn;
    logic [B-1:0] ReqData, RespData;
    logic         CmdInValid, CmdInReady, DataInValid, DataInReady;
    logic         ReturnDataValid, ReturnDataReady;
    logic [F-1:0] DataIn, ReturnData;

    int checks   = 0;
    int failures = 0;

    llc_oram_bridge #(.ORAMU(U), .ORAMB(B), .FEDWidth(F)) dut (
        .Clock(Clock), .Reset(Reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqCmd(ReqCmd),
        .ReqAddr(ReqAddr), .ReqData(ReqData),
        .RespValid(RespValid), .RespReady(RespReady), .RespData(RespData),
        .CmdInValid(CmdInValid), .CmdInReady(CmdInReady), .CmdIn(CmdIn),
        .ProgAddrIn(ProgAddrIn),
        .DataInValid(DataInValid), .DataInReady(DataInReady), .DataIn(DataIn),
        .ReturnDataValid(ReturnDataValid), .ReturnDataReady(ReturnDataReady),
        .ReturnData(ReturnData)
    );

    always #5 Clock = ~Clock;

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkW(input string tag, input logic [B-1:0] obs, input logic [B-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [B-1:0] randLine();
        logic [B-1:0] l;
        for (int i = 0; i < N; i++) l[i*F +: F] = $urandom;
        return l;
    endfunction

    task automatic checkAllZero(input string tag);
        check1({tag, "_reqready"}, ReqReady, 1'b0);
        check1({tag, "_respvalid"}, RespValid, 1'b0);
        check1({tag, "_cmdvalid"}, CmdInValid, 1'b0);
        check1({tag, "_datavalid"}, DataInValid, 1'b0);
        check1({tag, "_rdready"}, ReturnDataReady, 1'b0);
        checkW({tag, "_cmdin"}, B'(CmdIn), '0);
        checkW({tag, "_addr"}, B'(ProgAddrIn), '0);
        checkW({tag, "_datain"}, B'(DataIn), '0);
        checkW({tag, "_respdata"}, RespData, '0);
    endtask

    // One whole transaction seen from both sides. Called at a negedge; inputs
    // change only at negedges, so a transfer happens at the next posedge iff
    // the valid and ready seen/driven here are both 1. The line argument is
    // the write line or, for reads, the data the front end returns.
    task automatic runTxn(input logic [1:0] cmd, input logic [U-1:0] addr,
                          input logic [B-1:0] line, input int cmdPeriod,
                          input int dataMode, input int respHold,
                          input bit stray, input int abortAt);
        logic [F-1:0] fed[$];
        logic [B-1:0] expLine;
        int  k;
        bit  ok;
        ReqCmd = cmd; ReqAddr = addr; ReqData = randLine(); ReqValid = 1'b1;
        if (cmd >= 2'd2) ReqData = randLine(); else ReqData = line;
        ok = 1'b0;
        for (int cyc = 0; cyc < 50 && !ok; cyc++) begin
            if (ReqReady === 1'b1) begin
                check1("idle_cmdvalid", CmdInValid, 1'b0);
                ok = 1'b1;
            end
            @(negedge Clock);
        end
        ReqValid = 1'b0; ReqAddr = $urandom; ReqData = randLine(); ReqCmd = 2'($urandom_range(3));
        check1("req_accept", ok, 1'b1);
        ok = 1'b0;
        for (int cyc = 0; cyc < 400 && !ok; cyc++) begin
            check1("cmd_valid", CmdInValid, 1'b1);
            checkW("cmd_code", B'(CmdIn), B'(cmd));
            checkW("cmd_addr", B'(ProgAddrIn), B'(addr));
            check1("cmd_no_data", DataInValid, 1'b0);
            check1("cmd_no_rdready", ReturnDataReady, 1'b0);
            CmdInReady = (cyc % cmdPeriod == cmdPeriod - 1);
            if (CmdInReady) ok = 1'b1;
            @(negedge Clock);
        end
        CmdInReady = 1'b0;
        check1("cmd_done", ok, 1'b1);
        k = 0;
        if (cmd < 2'd2) begin
            for (int cyc = 0; cyc < 400 && k < N; cyc++) begin
                ReturnDataValid = stray; ReturnData = $urandom;
                check1("wr_valid", DataInValid, 1'b1);
                checkW("wr_chunk", B'(DataIn), B'(line[k*F +: F]));
                check1("wr_reqready", ReqReady, 1'b0);
                check1("wr_rdready", ReturnDataReady, 1'b0);
                check1("wr_cmdvalid", CmdInValid, 1'b0);
                DataInReady = (dataMode == 0) ? 1'b1 :
                              (dataMode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(1));
                if (DataInReady) k++;
                @(negedge Clock);
            end
            DataInReady = 1'b0; ReturnDataValid = 1'b0;
            checkW("wr_count", B'(k), B'(N));
            check1("wr_end_valid", DataInValid, 1'b0);
            check1("wr_no_resp", RespValid, 1'b0);
            check1("wr_end_reqready", ReqReady, 1'b1);
        end else begin
            for (int cyc = 0; cyc < 400 && k < N; cyc++) begin
                if (k == abortAt) break;
                check1("rd_ready", ReturnDataReady, 1'b1);
                check1("rd_no_resp", RespValid, 1'b0);
                ReturnDataValid = (dataMode == 0) ? 1'b1 :
                                  (dataMode == 1) ? (cyc % 2 == 1) : 1'($urandom_range(1));
                ReturnData = ReturnDataValid ? line[k*F +: F] : F'($urandom);
                if (ReturnDataValid) begin
                    fed.push_back(ReturnData);
                    k++;
                end
                @(negedge Clock);
            end
            ReturnDataValid = 1'b0;
            if (abortAt >= 0) return;
            checkW("rd_count", B'(k), B'(N));
            expLine = '0;
            foreach (fed[i]) expLine[i*F +: F] = fed[i];
            for (int cyc = 0; cyc < respHold; cyc++) begin
                check1("resp_hold_valid", RespValid, 1'b1);
                checkW("resp_hold_data", RespData, expLine);
                check1("resp_hold_reqready", ReqReady, 1'b0);
                @(negedge Clock);
            end
            check1("resp_valid", RespValid, 1'b1);
            checkW("resp_data", RespData, expLine);
            check1("resp_rdready", ReturnDataReady, 1'b0);
            RespReady = 1'b1;
            @(negedge Clock);
            RespReady = 1'b0;
            check1("resp_end_valid", RespValid, 1'b0);
            check1("resp_end_reqready", ReqReady, 1'b1);
            if (stray) begin
                for (int cyc = 0; cyc < 3; cyc++) begin
                    ReturnDataValid = 1'b1; ReturnData = $urandom;
                    @(negedge Clock);
                    check1("stray_idle_rdready", ReturnDataReady, 1'b0);
                    checkW("stray_idle_respdata", RespData, expLine);
                end
                ReturnDataValid = 1'b0;
            end
        end
    endtask

    initial begin
        logic [B-1:0] line;
        Reset = 1'b1; ReqValid = 1'b0; ReqCmd = 2'd0; ReqAddr = '0; ReqData = '0;
        RespReady = 1'b0; CmdInReady = 1'b0; DataInReady = 1'b0;
        ReturnDataValid = 1'b0; ReturnData = '0;
        repeat (3) @(negedge Clock);
        checkAllZero("reset");
        Reset = 1'b0;
        @(negedge Clock);
        check1("post_reset_reqready", ReqReady, 1'b1);

        for (int i = 0; i < N; i++) line[i*F +: F] = F'(i);
        runTxn(2'd2, 32'd700, line, 1, 0, 0, 1'b0, -1);

        for (int i = 0; i < N; i++) line[i*F +: F] = F'(32'h100 + i);
        runTxn(2'd0, 32'd600, line, 1, 0, 0, 1'b0, -1);

        runTxn(2'd0, $urandom, randLine(), 100, 1, 0, 1'b0, -1);
        runTxn(2'd2, $urandom, randLine(), 100, 1, 20, 1'b0, -1);

        runTxn(2'd1, 32'd513, randLine(), 1, 0, 0, 1'b1, -1);
        runTxn(2'd3, 32'd513, randLine(), 1, 0, 0, 1'b1, -1);

        runTxn(2'd2, 32'd42, randLine(), 1, 0, 0, 1'b0, 8);
        Reset = 1'b1;
        @(negedge Clock);
        checkAllZero("midreset");
        Reset = 1'b0;
        @(negedge Clock);
        check1("midreset_reqready", ReqReady, 1'b1);
        runTxn(2'd2, 32'd43, randLine(), 2, 2, 2, 1'b1, -1);

        for (int t = 0; t < 10; t++) begin
            runTxn(2'($urandom_range(3)), $urandom, randLine(),
                   int'($urandom_range(1, 4)), int'($urandom_range(2)),
                   int'($urandom_range(3)), 1'($urandom_range(1)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
